// File: rtl/instr_feeder.sv
// Host-to-dispatcher instruction feeder: loads words alternately into two FWFT
// slot queues, then streams them out to the dispatcher until both queues drain.

module instr_feeder_q #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [31:0]   wdata,
  input  logic          rd,
  output logic [31:0]   rdata,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          empty
);
  logic [31:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign cnt   = wptr - rptr;
  assign full  = cnt[AW];
  assign empty = (cnt == '0);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr && !full)  wptr <= wptr + 1'b1;
      if (rd && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (!rst && wr && !full) mem[wptr[AW-1:0]] <= wdata;
endmodule

module instr_feeder #(
  parameter int         DEPTH      = 512,
  parameter int         AW         = 9,
  parameter logic [3:0] END_OPCODE = 4'b0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  output logic          en_out0,
  output logic          en_out1,
  output logic [31:0]   instr_out0,
  output logic [31:0]   instr_out1,
  input  logic          en_ack0,
  input  logic          en_ack1,
  output logic          busy,
  output logic [AW+1:0] level
);
  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]          state;
  logic                wr_sel;
  logic [1:0]          wr, pop, full, empty, en_out, ack;
  logic [1:0][AW:0]    cnt;
  logic [1:0][31:0]    rdata;
  logic                is_end, xfer, store, tgt_full, tgt_last;
  logic [AW+1:0]       level_nxt;

  assign is_end   = (in_instr[31:28] == END_OPCODE);
  assign tgt_full = wr_sel ? full[1] : full[0];
  assign tgt_last = (wr_sel ? cnt[1] : cnt[0]) == (AW+1)'(DEPTH-1);
  assign in_ready = (state == S_LOAD) && !rst && !tgt_full;
  assign xfer     = in_valid && in_ready;
  assign store    = xfer && !is_end;
  assign wr       = {store && wr_sel, store && !wr_sel};
  assign ack      = {en_ack1, en_ack0};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_q
      // Head valid comes only from registered state, so the dispatcher's ack can
      // depend on it combinationally without forming a loop.
      assign en_out[g] = (state == S_RUN) && !empty[g];
      assign pop[g]    = en_out[g] && ack[g];
      instr_feeder_q #(.DEPTH(DEPTH), .AW(AW)) u_q (
        .clk(clk), .rst(rst), .wr(wr[g]), .wdata(in_instr), .rd(pop[g]),
        .rdata(rdata[g]), .cnt(cnt[g]), .full(full[g]), .empty(empty[g])
      );
    end
  endgenerate

  assign en_out0    = en_out[0];
  assign en_out1    = en_out[1];
  assign instr_out0 = rdata[0];
  assign instr_out1 = rdata[1];
  assign busy       = (state == S_RUN);
  assign level_nxt  = level + (AW+2)'(store) - (AW+2)'(pop[0]) - (AW+2)'(pop[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_LOAD;
      wr_sel <= 1'b0;
      level  <= '0;
    end else begin
      level <= level_nxt;
      case (state)
        S_LOAD: begin
          if (store) begin
            wr_sel <= ~wr_sel;
            if (tgt_last) state <= S_RUN;
          end
          if (xfer && is_end && level != '0) state <= S_RUN;
        end
        default: begin
          if (level_nxt == '0) begin
            state  <= S_LOAD;
            wr_sel <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule
